// File: rtl/evt_receiver.sv
// Host event-word receiver: frames AXI-stream words into keyed peripheral packets
// through a 2-entry buffer, enforcing a per-frame word limit and dropping partial words.
module evt_receiver #(
  parameter int PACKET_BITS = 72,
  parameter int KEY_LSB     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            evt_data_in,
  input  logic [3:0]             evt_keep_in,
  input  logic                   evt_last_in,
  input  logic                   evt_vld_in,
  output logic                   evt_rdy_out,
  input  logic [31:0]            key_base_in,
  input  logic [31:0]            key_mask_in,
  input  logic [9:0]             input_size_in,
  output logic [PACKET_BITS-1:0] pkt_data_out,
  output logic                   pkt_vld_out,
  input  logic                   pkt_rdy_in,
  output logic                   in_drp_cnt_out
);

  // state    | meaning
  // ---------+------------------------------------------------------------
  // IDLE     | between frames; next accepted word opens a frame (wcnt=0)
  // RECV     | inside a frame, words converted while wcnt < input_size_in
  // DISCARD  | frame exceeded its limit; drop words until last
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [9:0]             wcnt_q, wcnt_d;
  logic                   rdy_en_q;
  logic                   drp_q;
  logic [PACKET_BITS-1:0] fifo_mem [2];
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0]             count_q;

  logic                   full, empty;
  logic                   accept, push, pop, drop, over_size;
  logic [31:0]            key;
  logic [PACKET_BITS-1:0] pkt_new;

  assign full           = (count_q == 2'd2);
  assign empty          = (count_q == 2'd0);
  // Ready is held low through reset and only opens on the first edge after release.
  assign evt_rdy_out    = rdy_en_q && !full;
  assign pkt_vld_out    = !empty;
  assign pkt_data_out   = fifo_mem[rd_ptr_q];
  assign in_drp_cnt_out = drp_q;

  assign accept    = evt_vld_in && evt_rdy_out;
  assign pop       = pkt_vld_out && pkt_rdy_in;
  assign push      = accept && !drop;
  assign over_size = (input_size_in != 10'd0) && (wcnt_q >= input_size_in);

  assign key = (evt_data_in & key_mask_in) | key_base_in;

  always_comb begin
    pkt_new              = '0;
    pkt_new[KEY_LSB +: 32] = key;
    pkt_new[0]           = ~(^key);
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    drop    = 1'b0;
    if (accept) begin
      case (state_q)
        ST_IDLE, ST_RECV: begin
          if (over_size) begin
            drop    = 1'b1;
            state_d = evt_last_in ? ST_IDLE : ST_DISCARD;
            wcnt_d  = evt_last_in ? 10'd0 : wcnt_q;
          end else begin
            // Partial words still occupy a slot of the frame budget.
            drop    = (evt_keep_in != 4'hF);
            state_d = evt_last_in ? ST_IDLE : ST_RECV;
            wcnt_d  = evt_last_in ? 10'd0 : wcnt_q + 10'd1;
          end
        end
        ST_DISCARD: begin
          drop = 1'b1;
          if (evt_last_in) begin
            state_d = ST_IDLE;
            wcnt_d  = 10'd0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          wcnt_d  = 10'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= 10'd0;
      rdy_en_q <= 1'b0;
      drp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      rdy_en_q <= 1'b1;
      drp_q    <= accept && drop;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_q] <= pkt_new;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
